async_fifo: RTL and testbench



---
 rtl/async_fifo.sv | 72 +++++++
 tb/tb_async_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, full/empty status and
// one-cycle overflow/underflow error pulses.
module async_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  write_error,
  output logic                  read_error
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  wr_accept_c;
  logic                  rd_accept_c;

  // Status from pointers; the MSB is a wrap bit that separates full from empty.
  always_comb begin
    empty       = (wptr == rptr);
    full        = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                  (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    wr_accept_c = w_en && !full;
    rd_accept_c = r_en && !empty;
  end

  // Storage array; contents are never reset, pointers make them invisible.
  always_ff @(posedge wclk) begin
    if (wr_accept_c) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  // Write pointer and overflow pulse.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr        <= '0;
      write_error <= 1'b0;
    end else begin
      write_error <= w_en && full;
      if (wr_accept_c) begin
        wptr <= wptr + PTR_W'(1);
      end
    end
  end

  // Read pointer, registered read data and underflow pulse.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rptr       <= '0;
      data_out   <= '0;
      read_error <= 1'b0;
    end else begin
      read_error <= r_en && empty;
      if (rd_accept_c) begin
        data_out <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr     <= rptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: a vector table for short sequences plus
// hand-written fill/drain, overflow, underflow, simultaneous and wrap cases.
module tb_async_fifo;

  logic       wclk;
  logic       wrst_n;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       write_error;
  logic       read_error;

  int n_checks;
  int n_fails;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [7:0] exp_dout;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_werr;
    logic       exp_rerr;
  } vec_t;

  vec_t vecs[8];

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .w_en        (w_en),
    .r_en        (r_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .write_error (write_error),
    .read_error  (read_error)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] dout, input logic f,
                         input logic e, input logic we, input logic re);
    chk({name, ".data_out"}, 32'(data_out), 32'(dout));
    chk({name, ".full"}, 32'(full), 32'(f));
    chk({name, ".empty"}, 32'(empty), 32'(e));
    chk({name, ".write_error"}, 32'(write_error), 32'(we));
    chk({name, ".read_error"}, 32'(read_error), 32'(re));
  endtask

  // Drive one cycle of requests; returns 1 ns after the rising edge with inputs idle.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge wclk);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge wclk);
    #1;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] last_d;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    w_en     = 1'b0;
    r_en     = 1'b0;
    data_in  = 8'h00;
    wrst_n   = 1'b0;

    //        w     r     d      dout   full  empty werr  rerr
    vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};

    // Power-on reset
    repeat (2) @(posedge wclk);
    #1;
    chk_all("reset_state", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Vector table: simultaneous on empty, underflow, ordering
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full,
              vecs[i].exp_empty, vecs[i].exp_werr, vecs[i].exp_rerr);
    end

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk($sformatf("fill%0d.full", i), 32'(full), 32'(i == 15));
      chk($sformatf("fill%0d.empty", i), 32'(empty), 32'(0));
    end

    // Overflow: 0xAA dropped, error lasts one cycle
    step(1'b1, 1'b0, 8'hAA);
    chk_all("overflow", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk_all("overflow_clear", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);

    // Drain returns the original 16 words
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d.data", i), 32'(data_out), 32'(i));
      chk($sformatf("drain%0d.empty", i), 32'(empty), 32'(i == 15));
      chk($sformatf("drain%0d.full", i), 32'(full), 32'(0));
    end

    // Underflow for two cycles: data_out holds 0x0F
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk_all($sformatf("underflow%0d", i), 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00);
    chk_all("underflow_clear", 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);

    // Full FIFO with simultaneous access: read wins, write rejected
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    chk("refill.full", 32'(full), 32'(1));
    step(1'b1, 1'b1, 8'hBB);
    chk_all("both_full", 8'h20, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain2_%0d.data", i), 32'(data_out), 32'(8'h21 + i));
    end
    chk("drain2.empty", 32'(empty), 32'(1));

    // Half-full, both asserted for 20 cycles
    q = {};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i));
      q.push_back(8'(8'h40 + i));
    end
    for (int i = 0; i < 20; i++) begin
      exp_d = q.pop_front();
      q.push_back(8'(8'h60 + i));
      step(1'b1, 1'b1, 8'(8'h60 + i));
      chk_all($sformatf("half%0d", i), exp_d, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_d = q.pop_front();
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("half_drain%0d", i), 32'(data_out), 32'(exp_d));
    end
    chk("half_drain.empty", 32'(empty), 32'(1));

    // Wrap-around: 40 interleaved write/read pairs, occupancy between 1 and 2
    q = {};
    step(1'b1, 1'b0, 8'hC0);
    q.push_back(8'hC0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, 8'(k * 7 + 3));
      q.push_back(8'(k * 7 + 3));
      chk($sformatf("wrap_w%0d.flags", k), 32'({full, empty}), 32'(0));
      exp_d = q.pop_front();
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_r%0d.data", k), 32'(data_out), 32'(exp_d));
      chk($sformatf("wrap_r%0d.flags", k), 32'({full, empty}), 32'(0));
    end
    exp_d = q.pop_front();
    step(1'b0, 1'b1, 8'h00);
    chk("wrap_last.data", 32'(data_out), 32'(exp_d));
    chk("wrap_last.empty", 32'(empty), 32'(1));
    last_d = data_out;

    // Asynchronous reset mid-operation with 5 words stored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b0, 1'b1, 8'h00);
    chk("pre_reset.data", 32'(data_out), 32'(8'h70));
    @(negedge wclk);
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 8'hEE;
    #2;
    wrst_n = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge wclk);
    #1;
    chk_all("reset_held", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    w_en = 1'b0;
    r_en = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk_all("post_reset_read", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
